// File: rtl/dram_bank_scheduler.sv
// Round-robin scheduler sharing one open-page DRAM bank among NUM_REQ requesters.
// Grant is combinational in IDLE; bank timing (precharge/activate/burst) is counted here.
module dram_bank_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 10,
  parameter int ROW_WIDTH  = 512,
  parameter int BURST_LEN  = 4,
  parameter int PRE_CYCLES = 10,
  parameter int ACT_CYCLES = 20,
  localparam int COL_W     = $clog2(ROW_WIDTH / DATA_W)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_row,
  input  logic [NUM_REQ*COL_W-1:0]    req_col,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          wr_beat,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        dram_pre,
  output logic                        dram_act,
  output logic [ADDR_W-1:0]           dram_row,
  output logic                        dram_rd,
  output logic                        dram_wr,
  output logic [COL_W-1:0]            dram_col,
  output logic [DATA_W-1:0]           dram_wdata,
  input  logic [DATA_W-1:0]           dram_rdata,
  output logic                        busy,
  output logic                        open_valid,
  output logic [ADDR_W-1:0]           open_row
);

  localparam int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (ACT_CYCLES > PRE_CYCLES) ?
                           ((ACT_CYCLES > BURST_LEN) ? ACT_CYCLES : BURST_LEN) :
                           ((PRE_CYCLES > BURST_LEN) ? PRE_CYCLES : BURST_LEN);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, PRE, ACT, BURST} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [GNT_W-1:0]   rr_ptr;
  logic [GNT_W-1:0]   gnt_q;
  logic               we_q;
  logic [ADDR_W-1:0]  row_q;
  logic [COL_W-1:0]   col_q;
  logic               rd_pend;

  logic               gnt_found;
  logic [GNT_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  gnt_row;
  logic [NUM_REQ-1:0] arb_oh;
  logic [NUM_REQ-1:0] gnt_oh;

  // Search upward from rr_ptr with wrap-around; first pending requester wins.
  always_comb begin
    int j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = GNT_W'(j);
      end
    end
  end

  assign gnt_row = req_row[gnt_idx*ADDR_W +: ADDR_W];
  assign arb_oh  = NUM_REQ'(1) << gnt_idx;
  assign gnt_oh  = NUM_REQ'(1) << gnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      gnt_q      <= '0;
      we_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      rd_pend    <= 1'b0;
      open_valid <= 1'b0;
      open_row   <= '0;
    end else begin
      rd_pend <= (state == BURST) && !we_q;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            gnt_q  <= gnt_idx;
            we_q   <= req_we[gnt_idx];
            row_q  <= gnt_row;
            col_q  <= req_col[gnt_idx*COL_W +: COL_W];
            rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            cnt    <= '0;
            if (open_valid && open_row == gnt_row) state <= BURST;
            else if (open_valid)                   state <= PRE;
            else                                   state <= ACT;
          end
        end
        PRE: begin
          if (cnt == CNT_W'(PRE_CYCLES - 1)) begin
            cnt        <= '0;
            open_valid <= 1'b0;
            state      <= ACT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACT: begin
          if (cnt == CNT_W'(ACT_CYCLES - 1)) begin
            cnt        <= '0;
            open_valid <= 1'b1;
            open_row   <= row_q;
            state      <= BURST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BURST: begin
          if (cnt == CNT_W'(BURST_LEN - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE && gnt_found) ? arb_oh : '0;
  assign dram_pre  = (state == PRE) && (cnt == '0);
  assign dram_act  = (state == ACT) && (cnt == '0);
  assign dram_row  = dram_act ? row_q : '0;
  assign dram_rd   = (state == BURST) && !we_q;
  assign dram_wr   = (state == BURST) && we_q;
  // Column wraps within the row: the add simply overflows COL_W bits.
  assign dram_col   = (state == BURST) ? col_q + COL_W'(cnt) : '0;
  assign dram_wdata = dram_wr ? req_wdata[gnt_q*DATA_W +: DATA_W] : '0;
  assign wr_beat    = dram_wr ? gnt_oh : '0;
  assign rsp_valid  = rd_pend ? gnt_oh : '0;
  assign rsp_data   = rd_pend ? dram_rdata : '0;

endmodule

// File: tb/tb_dram_bank_scheduler.sv
// Directed bench for dram_bank_scheduler with a passive bank model.
module tb_dram_bank_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 10;
  localparam int COL_W   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_row;
  logic [NUM_REQ*COL_W-1:0]  req_col;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready, wr_beat, rsp_valid;
  logic [DATA_W-1:0]         rsp_data, dram_wdata, dram_rdata;
  logic                      dram_pre, dram_act, dram_rd, dram_wr, busy, open_valid;
  logic [ADDR_W-1:0]         dram_row, open_row;
  logic [COL_W-1:0]          dram_col;

  dram_bank_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_row(req_row), .req_col(req_col),
    .req_wdata(req_wdata), .req_ready(req_ready), .wr_beat(wr_beat),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .dram_pre(dram_pre), .dram_act(dram_act), .dram_row(dram_row),
    .dram_rd(dram_rd), .dram_wr(dram_wr), .dram_col(dram_col),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .busy(busy), .open_valid(open_valid), .open_row(open_row)
  );

  // Bank model: unwritten beats read back as {row, col} so data is traceable.
  logic [DATA_W-1:0] mem [0:1023][0:7];
  bit                written [0:1023][0:7];
  logic [ADDR_W-1:0] bank_row;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_row   <= '0;
      dram_rdata <= '0;
    end else begin
      if (dram_act) bank_row <= dram_row;
      if (dram_wr) begin
        mem[bank_row][dram_col]     <= dram_wdata;
        written[bank_row][dram_col] <= 1'b1;
      end
      if (dram_rd)
        dram_rdata <= written[bank_row][dram_col] ? mem[bank_row][dram_col]
                                                  : ((64'(bank_row) << 8) | 64'(dram_col));
      else
        dram_rdata <= '0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    int               req;
    bit               we;
    int               row;
    int               col;
    int               pre_at;  // cycle after grant of dram_pre, 0 = none
    int               act_at;  // cycle after grant of dram_act, 0 = none
    int               first;   // cycle after grant of first beat
    logic [3:0][2:0]  cols;
    logic [3:0][63:0] dat;
  } vec_t;

  function automatic vec_t mkv(int req, bit we, int row, int col, int pre_at, int act_at,
                               int first, int c0, int c1, int c2, int c3,
                               logic [63:0] d0, logic [63:0] d1, logic [63:0] d2,
                               logic [63:0] d3);
    vec_t v;
    v.req = req; v.we = we; v.row = row; v.col = col;
    v.pre_at = pre_at; v.act_at = act_at; v.first = first;
    v.cols[0] = 3'(c0); v.cols[1] = 3'(c1); v.cols[2] = 3'(c2); v.cols[3] = 3'(c3);
    v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    logic [NUM_REQ-1:0] oh;
    logic [19:0]        exp_w, got_w;
    int                 beat;
    bit                 in_b, e_wr, e_rsp;
    oh = NUM_REQ'(1) << v.req;
    @(negedge clk);
    req_valid = oh;
    req_we[v.req] = v.we;
    req_row[v.req*ADDR_W +: ADDR_W] = ADDR_W'(v.row);
    req_col[v.req*COL_W +: COL_W] = COL_W'(v.col);
    #1;
    check("grant", 64'(req_ready), 64'(oh));
    check("busy_at_grant", 64'(busy), 64'd0);
    @(negedge clk);
    req_valid = '0;
    for (int k = 1; k <= v.first + 4; k++) begin
      if (k > 1) @(negedge clk);
      beat  = k - v.first;
      in_b  = (beat >= 0) && (beat < 4);
      e_wr  = in_b && v.we;
      e_rsp = !v.we && (beat >= 1) && (beat <= 4);
      if (e_wr) req_wdata[v.req*DATA_W +: DATA_W] = v.dat[beat];
      #1;
      exp_w = {4'b0, 1'(k == v.pre_at), 1'(k == v.act_at), 1'(in_b && !v.we), 1'(e_wr),
               in_b ? v.cols[beat] : 3'd0, e_wr ? oh : 4'd0, e_rsp ? oh : 4'd0,
               1'(k < v.first + 4)};
      got_w = {req_ready, dram_pre, dram_act, dram_rd, dram_wr, dram_col,
               wr_beat, rsp_valid, busy};
      check($sformatf("req%0d_cycle_T+%0d", v.req, k), 64'(got_w), 64'(exp_w));
      if (k == v.act_at) check("act_row", 64'(dram_row), 64'(v.row));
      if (e_wr) check($sformatf("wdata_beat%0d", beat), dram_wdata, v.dat[beat]);
      if (e_rsp) check($sformatf("rdata_beat%0d", beat - 1), rsp_data, v.dat[beat - 1]);
    end
    check("open_valid", 64'(open_valid), 64'd1);
    check("open_row", 64'(open_row), 64'(v.row));
  endtask

  vec_t vecs [6];
  int   exp_order [5] = '{0, 1, 2, 3, 0};
  int   exp_gap   [5] = '{0, 25, 5, 5, 5};

  initial begin
    int ng, last_t;
    req_valid = '0; req_we = '0; req_row = '0; req_col = '0;
    req_wdata = {4{64'hDEAD_BEEF_0000_0000}};

    vecs[0] = mkv(0, 0, 5,   2, 0, 1,  21, 2, 3, 4, 5, 64'h502, 64'h503, 64'h504, 64'h505);
    vecs[1] = mkv(1, 1, 5,   6, 0, 0,  1,  6, 7, 0, 1, 64'hA, 64'hB, 64'hC, 64'hD);
    vecs[2] = mkv(2, 0, 5,   6, 0, 0,  1,  6, 7, 0, 1, 64'hA, 64'hB, 64'hC, 64'hD);
    vecs[3] = mkv(3, 0, 9,   0, 1, 11, 31, 0, 1, 2, 3, 64'h900, 64'h901, 64'h902, 64'h903);
    vecs[4] = mkv(2, 1, 100, 0, 1, 11, 31, 0, 1, 2, 3, 64'd1, 64'd2, 64'd3, 64'd4);
    vecs[5] = mkv(3, 0, 100, 0, 0, 0,  1,  0, 1, 2, 3, 64'd1, 64'd2, 64'd3, 64'd4);

    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 64'({busy, open_valid, open_row, req_ready, wr_beat, rsp_valid,
                              dram_pre, dram_act, dram_rd, dram_wr, dram_col}), 64'd0);
    check("reset_data", rsp_data | dram_wdata | 64'(dram_row), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset while a conflicting request sits in ACT.
    @(negedge clk);
    req_valid = 4'b0001; req_we[0] = 1'b0;
    req_row[0 +: ADDR_W] = 10'd7; req_col[0 +: COL_W] = 3'd0;
    #1 check("grant_before_reset", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = '0;
    repeat (14) @(negedge clk);
    #1 check("busy_in_act", 64'({busy, dram_pre, dram_rd}), 64'h4);
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", 64'({busy, open_valid, open_row}), 64'd0);
    check("rst_mid_cmds", 64'({req_ready, wr_beat, rsp_valid, dram_pre, dram_act, dram_row,
                               dram_rd, dram_wr, dram_col}), 64'd0);
    check("rst_mid_data", rsp_data | dram_wdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(mkv(1, 0, 5, 2, 0, 1, 21, 2, 3, 4, 5, 64'h502, 64'h503, 64'h504, 64'h505));

    // Fairness: all requesters pending from reset, same row.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_we = '0; req_row = {4{10'd5}}; req_col = '0; req_valid = 4'hF;
    ng = 0; last_t = 0;
    for (int cyc = 0; cyc < 200 && ng < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (req_ready != '0) begin
        check($sformatf("fair_grant%0d", ng), 64'(req_ready), 64'(4'(1) << exp_order[ng]));
        if (ng > 0) check($sformatf("fair_gap%0d", ng), 64'(cyc - last_t), 64'(exp_gap[ng]));
        last_t = cyc;
        ng++;
      end
    end
    check("fair_grant_count", 64'(ng), 64'd5);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
